// File: rtl/if_queue.sv
// Instruction fetch queue: circular buffer of DEPTH fetched instructions, accepts
// up to two per cycle from fetch and presents the oldest two to decode.
package if_queue_pkg;
   typedef enum logic {INVALID = 1'b0, VALID = 1'b1} valid_e;

   typedef struct packed {
      valid_e      is_valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } Inst_PC;

   typedef struct packed {
      Inst_PC A;
      Inst_PC B;
   } Inst_PC_N;
endpackage

module if_queue
   import if_queue_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  Inst_PC_N               in_pair,
   output logic                   in_ready,
   output Inst_PC_N               out_pair,
   input  logic [1:0]             pop,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [CW-1:0] r_count;
   Inst_PC        r_mem [DEPTH];

   logic [1:0]    w_pop_req;
   logic [1:0]    w_pop_eff;
   logic [1:0]    w_push_cnt;
   logic          w_push_a;
   logic          w_push_b;
   logic [AW-1:0] w_tail_b;
   logic [AW-1:0] w_head_b;

   // pop[1] without pop[0] would consume out of order, so it is ignored
   always_comb begin
      w_pop_req = 2'd0;
      if (pop[0]) w_pop_req = pop[1] ? 2'd2 : 2'd1;
      w_pop_eff = (r_count < CW'(w_pop_req)) ? r_count[1:0] : w_pop_req;
   end

   assign w_push_a   = in_ready && !flush && (in_pair.A.is_valid == VALID);
   assign w_push_b   = in_ready && !flush && (in_pair.B.is_valid == VALID);
   assign w_push_cnt = {1'b0, w_push_a} + {1'b0, w_push_b};
   assign w_tail_b   = r_tail + AW'(w_push_a);
   assign w_head_b   = r_head + AW'(1);

   always_ff @(posedge clk) begin
      if (w_push_a) r_mem[r_tail]   <= in_pair.A;
      if (w_push_b) r_mem[w_tail_b] <= in_pair.B;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + AW'(w_pop_eff);
         r_tail  <= r_tail + AW'(w_push_cnt);
         r_count <= r_count + CW'(w_push_cnt) - CW'(w_pop_eff);
      end
   end

   assign in_ready = (r_count <= CW'(DEPTH - 2));
   assign empty    = (r_count == '0);
   assign full     = (r_count == CW'(DEPTH));
   assign count    = r_count;

   // Uncounted slots are masked to zero so stale storage never leaks out
   always_comb begin
      out_pair            = '0;
      out_pair.A.is_valid = INVALID;
      out_pair.B.is_valid = INVALID;
      if (r_count >= CW'(1)) begin
         out_pair.A          = r_mem[r_head];
         out_pair.A.is_valid = VALID;
      end
      if (r_count >= CW'(2)) begin
         out_pair.B          = r_mem[w_head_b];
         out_pair.B.is_valid = VALID;
      end
   end

endmodule

// File: tb/tb_if_queue.sv
// Directed bench for if_queue: a table of single-cycle vectors followed by
// hand-written streaming, wrap-around and asynchronous reset sequences.
module tb_if_queue;
   import if_queue_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   Inst_PC_N   in_pair;
   logic       in_ready;
   Inst_PC_N   out_pair;
   logic [1:0] pop = 2'b00;
   logic [3:0] count;
   logic       empty;
   logic       full;

   int checks = 0;
   int errors = 0;

   if_queue #(.DEPTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_pair  (in_pair),
      .in_ready (in_ready),
      .out_pair (out_pair),
      .pop      (pop),
      .count    (count),
      .empty    (empty),
      .full     (full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fl;
      logic [1:0]  pp;
      logic        va;
      logic [31:0] pa;
      logic        vb;
      logic [31:0] pb;
      int          cnt;
      logic        ea;
      logic [31:0] ea_pc;
      logic        eb;
      logic [31:0] eb_pc;
      logic        rdy;
      logic        ful;
   } vec_t;

   vec_t tbl [21];

   function automatic logic [31:0] ins_of(logic [31:0] pc);
      if (pc == 32'h0) return 32'h0050_0093;
      if (pc == 32'h4) return 32'h00A0_0113;
      return {16'hC0DE, pc[15:0]};
   endfunction

   function automatic vec_t mk(logic fl, logic [1:0] pp, logic va, logic [31:0] pa,
                               logic vb, logic [31:0] pb, int cnt, logic ea,
                               logic [31:0] ea_pc, logic eb, logic [31:0] eb_pc,
                               logic rdy, logic ful);
      vec_t v;
      v.fl = fl; v.pp = pp; v.va = va; v.pa = pa; v.vb = vb; v.pb = pb;
      v.cnt = cnt; v.ea = ea; v.ea_pc = ea_pc; v.eb = eb; v.eb_pc = eb_pc;
      v.rdy = rdy; v.ful = ful;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic fl, input logic [1:0] pp, input logic va,
                        input logic [31:0] pa, input logic vb, input logic [31:0] pb);
      flush = fl;
      pop   = pp;
      in_pair.A.is_valid = va ? VALID : INVALID;
      in_pair.A.pc       = pa;
      in_pair.A.instr    = ins_of(pa);
      in_pair.B.is_valid = vb ? VALID : INVALID;
      in_pair.B.pc       = pb;
      in_pair.B.instr    = ins_of(pb);
   endtask

   task automatic chk_out(input string tag, input int cnt, input logic ea,
                          input logic [31:0] ea_pc, input logic eb, input logic [31:0] eb_pc);
      chk({tag, " count"}, 64'(count), 64'(cnt));
      chk({tag, " empty"}, 64'(empty), 64'(cnt == 0));
      chk({tag, " A.valid"}, 64'(out_pair.A.is_valid), 64'(ea));
      chk({tag, " A.pc"}, 64'(out_pair.A.pc), ea ? 64'(ea_pc) : 64'd0);
      chk({tag, " A.instr"}, 64'(out_pair.A.instr), ea ? 64'(ins_of(ea_pc)) : 64'd0);
      chk({tag, " B.valid"}, 64'(out_pair.B.is_valid), 64'(eb));
      chk({tag, " B.pc"}, 64'(out_pair.B.pc), eb ? 64'(eb_pc) : 64'd0);
      chk({tag, " B.instr"}, 64'(out_pair.B.instr), eb ? 64'(ins_of(eb_pc)) : 64'd0);
   endtask

   initial begin
      logic [31:0] exp_pc;

      drive(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);

      //          fl  pop    vA  pcA    vB  pcB    cnt A  Apc    B  Bpc    rdy full
      tbl[0]  = mk(0, 2'b00, 1, 32'h00, 1, 32'h04, 2, 1, 32'h00, 1, 32'h04, 1, 0);
      tbl[1]  = mk(0, 2'b00, 1, 32'h08, 1, 32'h0C, 4, 1, 32'h00, 1, 32'h04, 1, 0);
      tbl[2]  = mk(0, 2'b00, 1, 32'h10, 1, 32'h14, 6, 1, 32'h00, 1, 32'h04, 1, 0);
      tbl[3]  = mk(0, 2'b00, 1, 32'h18, 1, 32'h1C, 8, 1, 32'h00, 1, 32'h04, 0, 1);
      tbl[4]  = mk(0, 2'b00, 1, 32'h20, 1, 32'h24, 8, 1, 32'h00, 1, 32'h04, 0, 1);
      tbl[5]  = mk(0, 2'b10, 0, 32'h00, 0, 32'h00, 8, 1, 32'h00, 1, 32'h04, 0, 1);
      tbl[6]  = mk(0, 2'b01, 0, 32'h00, 0, 32'h00, 7, 1, 32'h04, 1, 32'h08, 0, 0);
      tbl[7]  = mk(0, 2'b11, 0, 32'h00, 0, 32'h00, 5, 1, 32'h0C, 1, 32'h10, 1, 0);
      tbl[8]  = mk(0, 2'b00, 0, 32'h00, 1, 32'h20, 6, 1, 32'h0C, 1, 32'h10, 1, 0);
      tbl[9]  = mk(0, 2'b11, 0, 32'h00, 0, 32'h00, 4, 1, 32'h14, 1, 32'h18, 1, 0);
      tbl[10] = mk(0, 2'b11, 0, 32'h00, 0, 32'h00, 2, 1, 32'h1C, 1, 32'h20, 1, 0);
      tbl[11] = mk(0, 2'b11, 1, 32'h40, 1, 32'h44, 2, 1, 32'h40, 1, 32'h44, 1, 0);
      tbl[12] = mk(0, 2'b01, 0, 32'h00, 0, 32'h00, 1, 1, 32'h44, 0, 32'h00, 1, 0);
      tbl[13] = mk(0, 2'b11, 0, 32'h00, 0, 32'h00, 0, 0, 32'h00, 0, 32'h00, 1, 0);
      tbl[14] = mk(0, 2'b11, 0, 32'h00, 0, 32'h00, 0, 0, 32'h00, 0, 32'h00, 1, 0);
      tbl[15] = mk(0, 2'b00, 1, 32'h48, 0, 32'h00, 1, 1, 32'h48, 0, 32'h00, 1, 0);
      tbl[16] = mk(0, 2'b00, 1, 32'h4C, 1, 32'h50, 3, 1, 32'h48, 1, 32'h4C, 1, 0);
      tbl[17] = mk(0, 2'b10, 0, 32'h00, 0, 32'h00, 3, 1, 32'h48, 1, 32'h4C, 1, 0);
      tbl[18] = mk(0, 2'b00, 1, 32'h54, 1, 32'h58, 5, 1, 32'h48, 1, 32'h4C, 1, 0);
      tbl[19] = mk(1, 2'b11, 1, 32'h5C, 1, 32'h60, 0, 0, 32'h00, 0, 32'h00, 1, 0);
      tbl[20] = mk(0, 2'b00, 1, 32'h64, 1, 32'h68, 2, 1, 32'h64, 1, 32'h68, 1, 0);

      repeat (2) @(negedge clk);
      chk_out("reset", 0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("reset in_ready", 64'(in_ready), 64'd1);
      chk("reset full", 64'(full), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         drive(tbl[i].fl, tbl[i].pp, tbl[i].va, tbl[i].pa, tbl[i].vb, tbl[i].pb);
         @(posedge clk);
         #1;
         chk_out($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].ea, tbl[i].ea_pc,
                 tbl[i].eb, tbl[i].eb_pc);
         chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(tbl[i].rdy));
         chk($sformatf("vec%0d full", i), 64'(full), 64'(tbl[i].ful));
      end

      // Streaming: two in, two out per cycle, across several pointer wraps
      @(negedge clk);
      drive(1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      exp_pc = 32'h200;
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, (i == 0) ? 2'b00 : 2'b11, 1'b1, 32'h200 + 32'(8 * i),
               1'b1, 32'h204 + 32'(8 * i));
         @(posedge clk);
         #1;
         chk_out($sformatf("stream%0d", i), 2, 1'b1, exp_pc, 1'b1, exp_pc + 32'h4);
         exp_pc = exp_pc + 32'h8;
         @(negedge clk);
      end

      // Asynchronous reset in the middle of the stream
      drive(1'b0, 2'b00, 1'b1, 32'h300, 1'b1, 32'h304);
      @(posedge clk);
      #2;
      chk("pre-reset count", 64'(count), 64'd4);
      rst_n = 1'b0;
      #1;
      chk_out("async reset", 0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("async reset in_ready", 64'(in_ready), 64'd1);
      drive(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 2'b00, 1'b1, 32'h100, 1'b1, 32'h104);
      @(posedge clk);
      #1;
      chk_out("after reset", 2, 1'b1, 32'h100, 1'b1, 32'h104);
      @(negedge clk);
      drive(1'b0, 2'b11, 1'b0, 32'h0, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      chk_out("drain", 0, 1'b0, 32'h0, 1'b0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
